fork_dispatch: RTL and testbench

//  Clocked fork stage: accepts one token on a valid/ready input and broadcasts it
//  to N branch consumers, each with its own valid/ready handshake (eager fork).

---
 rtl/fork_pkg.sv | 6 +
 rtl/fork_tmo_counter.sv | 19 +
 rtl/fork_dispatch.sv | 79 +++++++
 tb/tb_fork_dispatch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fork_pkg.sv
// fork_pkg: shared FSM state type and sizing constants for the fork dispatch stage
package fork_pkg;
    typedef enum logic {IDLE, ISSUE} fork_state_t;
    localparam int FORK_MAX_N = 16;
    localparam int FORK_CNT_W = 8;
endpackage

// File: rtl/fork_tmo_counter.sv
// fork_tmo_counter: per-token issue-cycle counter flagging the last cycle before timeout
module fork_tmo_counter
    import fork_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [FORK_CNT_W-1:0] tmo,
    output logic                  expired
);
    logic [FORK_CNT_W-1:0] cnt;
    assign expired = en && (cnt == tmo - 1'b1);
    // count issue cycles, restarting at every token capture
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/fork_dispatch.sv
// fork_dispatch: eager fork of one valid/ready token to N branches with join-all release (optional FORK_TIMEOUT_EN)
module fork_dispatch
    import fork_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic [N-1:0]     drop_mask
);
    fork_state_t state;
    logic [N-1:0] pending;
    logic [N-1:0] residual;
    logic         cap;
    logic         tmo_hit;
    assign in_ready  = state == IDLE;
    assign busy      = state == ISSUE;
    assign out_valid = pending;
    assign cap       = in_valid && in_ready;
    assign residual  = pending & ~out_ready;
`ifdef FORK_TIMEOUT_EN
    logic         expired;
    logic         err_q;
    logic [N-1:0] drop_q;
    fork_tmo_counter u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (cap),
        .en     (state == ISSUE),
        .tmo    (FORK_CNT_W'(TMO)),
        .expired(expired)
    );
    assign tmo_hit     = expired && (residual != '0);
    assign timeout_err = err_q;
    assign drop_mask   = drop_q;
    // one-cycle error pulse; drop mask holds until the next capture
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= tmo_hit;
            if (cap) drop_q <= '0;
            else if (tmo_hit) drop_q <= residual;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign drop_mask   = '0;
`endif
    // capture in IDLE, retire branches as they accept, release once none remain
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            out_data <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                out_data <= in_data;
                pending  <= '1;
                state    <= ISSUE;
            end
        end else begin
            pending <= tmo_hit ? '0 : residual;
            if (residual == '0 || tmo_hit) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_fork_dispatch.sv
// tb_fork_dispatch: directed self-checking bench for fork_dispatch (N=3, WIDTH=8)
module tb_fork_dispatch;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [2:0] out_valid;
    logic [2:0] out_ready = '0;
    logic       busy;
    logic       timeout_err;
    logic [2:0] drop_mask;
    int checks = 0;
    int failures = 0;
    int hs_cnt [3] = '{0, 0, 0};
    int hs_sum [3] = '{0, 0, 0};
    int snap_cnt [3];
    int snap_sum [3];

    fork_dispatch #(.WIDTH(8), .N(3), .TMO(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err),
        .drop_mask  (drop_mask)
    );

    always #5 clk = ~clk;

    // per-branch handshake log
    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                if (out_valid[b] && out_ready[b]) begin
                    hs_cnt[b] = hs_cnt[b] + 1;
                    hs_sum[b] = hs_sum[b] + int'(out_data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int b = 0; b < 3; b++) begin
            snap_cnt[b] = hs_cnt[b];
            snap_sum[b] = hs_sum[b];
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo_err", 32'(timeout_err), 0);
        chk("rst_drop", 32'(drop_mask), 0);
        chk("rst_out_data", 32'(out_data), 0);

        in_data = 8'hA5; in_valid = 1'b1; out_ready = 3'b111;
        tick();
        chk("all_ov", 32'(out_valid), 32'h7);
        chk("all_od", 32'(out_data), 32'hA5);
        chk("all_in_ready", 32'(in_ready), 0);
        chk("all_busy", 32'(busy), 1);
        in_valid = 1'b0;
        tick();
        chk("all_ov_done", 32'(out_valid), 0);
        chk("all_in_ready_back", 32'(in_ready), 1);

        in_data = 8'h11; in_valid = 1'b1; out_ready = 3'b000;
        tick();
        chk("stg_ov0", 32'(out_valid), 32'h7);
        in_data = 8'h3C;
        out_ready = 3'b001; tick();
        chk("stg_ov1", 32'(out_valid), 32'h6);
        out_ready = 3'b001; tick();
        chk("stg_ov2_ignored", 32'(out_valid), 32'h6);
        chk("stg_od_stable", 32'(out_data), 32'h11);
        out_ready = 3'b100; tick();
        chk("stg_ov3", 32'(out_valid), 32'h2);
        out_ready = 3'b000; tick();
        chk("stg_ov4", 32'(out_valid), 32'h2);
        chk("stg_no_capture", 32'(in_ready), 0);
        out_ready = 3'b010; tick();
        chk("stg_ov5", 32'(out_valid), 0);
        chk("stg_in_ready", 32'(in_ready), 1);
        chk("stg_od_held", 32'(out_data), 32'h11);
        out_ready = 3'b000; tick();
        chk("stg_new_ov", 32'(out_valid), 32'h7);
        chk("stg_new_od", 32'(out_data), 32'h3C);
        in_valid = 1'b0; out_ready = 3'b111; tick();
        chk("stg_new_done", 32'(in_ready), 1);

        snap();
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i); in_valid = 1'b1; out_ready = 3'b111;
            tick();
            chk("b2b_ov", 32'(out_valid), 32'h7);
            chk("b2b_od", 32'(out_data), 32'(i));
            tick();
            chk("b2b_idle", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("b2b_hs_cnt", 32'(hs_cnt[b] - snap_cnt[b]), 4);
            chk("b2b_hs_sum", 32'(hs_sum[b] - snap_sum[b]), 10);
        end

        in_data = 8'h77; in_valid = 1'b1; out_ready = 3'b001;
        tick();
        chk("mid_ov0", 32'(out_valid), 32'h7);
        in_valid = 1'b0;
        tick();
        chk("mid_ov1", 32'(out_valid), 32'h6);
        reset = 1'b1; out_ready = 3'b000;
        tick();
        chk("mid_ov_rst", 32'(out_valid), 0);
        chk("mid_busy_rst", 32'(busy), 0);
        chk("mid_tmo_rst", 32'(timeout_err), 0);
        reset = 1'b0; out_ready = 3'b111;
        snap();
        tick(); tick(); tick();
        chk("mid_hs_none", 32'(hs_cnt[1] - snap_cnt[1] + hs_cnt[2] - snap_cnt[2]), 0);
        chk("mid_tmo_none", 32'(timeout_err), 0);
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_od_cleared", 32'(out_data), 0);

`ifdef FORK_TIMEOUT_EN
        begin
            int t;
            in_data = 8'h5A; in_valid = 1'b1; out_ready = 3'b101;
            tick();
            in_valid = 1'b0;
            t = 0;
            while (!timeout_err && t < 40) begin
                tick();
                t++;
            end
            chk("tmo_cycles", 32'(t), 15);
            chk("tmo_drop", 32'(drop_mask), 32'h2);
            chk("tmo_in_ready", 32'(in_ready), 1);
            chk("tmo_ov", 32'(out_valid), 0);
            tick();
            chk("tmo_pulse_end", 32'(timeout_err), 0);
            chk("tmo_drop_held", 32'(drop_mask), 32'h2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
